// File: rtl/icache_assoc.sv
// icache_assoc: parametrised N-way set-associative instruction cache with true-LRU
// replacement, word-serial line refill and flush. Define ICACHE_STATS_EN for hit/miss counters.
module icache_assoc #(
    parameter int WAYS       = 2,
    parameter int SETS       = 8,
    parameter int LINE_WORDS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ins_req,
    input  logic [31:0] instraddr,
    output logic [31:0] instr,
    output logic        hit,
    output logic        stall,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
`ifdef ICACHE_STATS_EN
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses,
`endif
    input  logic        mem_val
);
    localparam int OFF_W  = $clog2(LINE_WORDS) + 2;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 32 - IDX_W - OFF_W;
    localparam int WSEL_W = $clog2(LINE_WORDS);
    localparam int AGE_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int WAY_W  = AGE_W;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_REFILL = 3'd2;
    localparam logic [2:0] S_FILL   = 3'd3;
    localparam logic [2:0] S_FLUSH  = 3'd4;

    typedef logic [LINE_WORDS-1:0][31:0] line_t;

    logic [2:0]        state_q, state_d;
    logic [31:2]       addr_q, addr_d;
    logic [WSEL_W-1:0] cnt_q, cnt_d;
    logic              flush_pend_q, flush_pend_d;
    line_t             line_buf_q;

    logic [SETS-1:0][WAYS-1:0] valid_q;
    logic [TAG_W-1:0]          tag_q  [WAYS][SETS];
    line_t                     data_q [WAYS][SETS];
    logic [AGE_W-1:0]          age_q  [SETS][WAYS];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [WSEL_W-1:0] wsel;
    logic [WAYS-1:0]   way_hit;
    logic [WAY_W-1:0]  hit_way, victim, upd_way;
    logic [AGE_W-1:0]  old_age;
    logic              lookup_hit, found_inv;
    logic              hit_fire, miss_fire, fill_fire;
    logic              unused_low_bits;

    assign idx  = addr_q[OFF_W +: IDX_W];
    assign tag  = addr_q[31 -: TAG_W];
    assign wsel = addr_q[2 +: WSEL_W];
    assign unused_low_bits = ^instraddr[1:0];

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        way_hit = '0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            way_hit[w] = valid_q[idx][w] && (tag_q[w][idx] == tag);
            if (way_hit[w]) hit_way = WAY_W'(w);
        end
    end
    assign lookup_hit = |way_hit;

    // Victim: lowest invalid way, otherwise the oldest (age WAYS-1).
    always_comb begin
        victim    = '0;
        found_inv = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) begin
                victim    = WAY_W'(w);
                found_inv = 1'b1;
            end
        end
        if (!found_inv) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[idx][w] == AGE_W'(WAYS - 1)) victim = WAY_W'(w);
            end
        end
    end

    assign hit_fire  = (state_q == S_LOOKUP) && lookup_hit && !flush;
    assign miss_fire = (state_q == S_LOOKUP) && !lookup_hit && !flush;
    assign fill_fire = (state_q == S_FILL);
    assign upd_way   = fill_fire ? victim : hit_way;
    assign old_age   = age_q[idx][upd_way];

    // NOTE: blocking assignments here model pure combinational next-state logic; registers use <= only.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    state_d = S_FLUSH;
                end else if (ins_req) begin
                    addr_d  = instraddr[31:2];
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (flush)            state_d = S_FLUSH;
                else if (!lookup_hit) state_d = S_REFILL;
                else if (ins_req)     addr_d  = instraddr[31:2];
                else                  state_d = S_IDLE;
            end
            S_REFILL: begin
                if (flush) flush_pend_d = 1'b1;
                if (mem_val) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == '1) state_d = S_FILL;
                end
            end
            S_FILL: begin
                // A flush seen during the refill wins over the re-lookup; the fetch re-issues.
                state_d      = (flush || flush_pend_q) ? S_FLUSH : S_LOOKUP;
                flush_pend_d = 1'b0;
            end
            S_FLUSH: begin
                state_d      = S_IDLE;
                flush_pend_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) age_q[s][w] <= AGE_W'(w);
            end
        end else begin
            if (state_q == S_FLUSH) valid_q <= '0;
            else if (fill_fire)     valid_q[idx][victim] <= 1'b1;
            if (hit_fire || fill_fire) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == upd_way)      age_q[idx][w] <= '0;
                    else if (age_q[idx][w] < old_age) age_q[idx][w] <= age_q[idx][w] + 1'b1;
                end
            end
        end
    end

    // NOTE: tag/data arrays and the line buffer are not reset; valid bits alone gate their use.
    always_ff @(posedge clk) begin
        if (state_q == S_REFILL && mem_val) line_buf_q[cnt_q] <= mem_data;
        if (fill_fire) begin
            tag_q[victim][idx]  <= tag;
            data_q[victim][idx] <= line_buf_q;
        end
    end

    assign hit      = hit_fire;
    assign instr    = hit_fire ? data_q[hit_way][idx][wsel] : '0;
    assign stall    = miss_fire || (state_q == S_REFILL) || (state_q == S_FILL) || (state_q == S_FLUSH);
    assign mem_req  = (state_q == S_REFILL);
    assign mem_addr = mem_req ? {addr_q[31:OFF_W], {OFF_W{1'b0}}} : '0;

`ifdef ICACHE_STATS_EN
    logic [31:0] hits_q, misses_q;
    logic        relookup_q;

    // The first lookup after a fill is the refill's own re-lookup and is not counted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hits_q     <= '0;
            misses_q   <= '0;
            relookup_q <= 1'b0;
        end else begin
            relookup_q <= fill_fire && (state_d == S_LOOKUP);
            if (hit_fire && !relookup_q && hits_q != '1) hits_q <= hits_q + 1'b1;
            if (miss_fire && misses_q != '1)             misses_q <= misses_q + 1'b1;
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`endif

endmodule

// File: tb/tb_icache_assoc.sv
// tb_icache_assoc: scoreboard bench for icache_assoc with a zero-wait word-serial memory
// and an MRU-ordered reference model of which lines are resident.
`timescale 1ns/1ps
module tb_icache_assoc;
    localparam int WAYS       = 2;
    localparam int SETS       = 8;
    localparam int LINE_WORDS = 8;
    localparam int OFF_W      = 5;
    localparam int IDX_W      = 3;
    localparam int TAG_W      = 32 - IDX_W - OFF_W;
    localparam int MISS_LAT   = LINE_WORDS + 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ins_req = 1'b0;
    logic        flush = 1'b0;
    logic        mem_val = 1'b0;
    logic [31:0] instraddr = '0;
    logic [31:0] mem_data = '0;
    logic [31:0] instr, mem_addr;
    logic        hit, stall, mem_req;
`ifdef ICACHE_STATS_EN
    logic [31:0] stat_hits, stat_misses;
`endif

    icache_assoc #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LINE_WORDS)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .ins_req    (ins_req),
        .instraddr  (instraddr),
        .instr      (instr),
        .hit        (hit),
        .stall      (stall),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
`ifdef ICACHE_STATS_EN
        .stat_hits  (stat_hits),
        .stat_misses(stat_misses),
`endif
        .mem_val    (mem_val)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) + 32'h0000_0FF0;
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    // Reference model: per set, resident tags ordered most- to least-recently used.
    logic [TAG_W-1:0] mdl_tag [SETS][WAYS];
    int               mdl_n   [SETS];

    function automatic void model_clear();
        for (int s = 0; s < SETS; s++) mdl_n[s] = 0;
    endfunction

    function automatic bit model_access(input logic [31:0] a);
        int s;
        int pos;
        logic [TAG_W-1:0] t;
        s   = int'(a[OFF_W +: IDX_W]);
        t   = a[31 -: TAG_W];
        pos = -1;
        for (int i = 0; i < mdl_n[s]; i++) if (mdl_tag[s][i] == t) pos = i;
        model_access = (pos >= 0);
        if (pos < 0) begin
            if (mdl_n[s] < WAYS) mdl_n[s]++;
            pos = mdl_n[s] - 1;
        end
        for (int i = pos; i > 0; i--) mdl_tag[s][i] = mdl_tag[s][i-1];
        mdl_tag[s][0] = t;
    endfunction

    // Memory: answers one cycle after it first sees mem_req, then one word per cycle.
    int words_sent = 0;
    initial begin
        logic req_prev;
        req_prev = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (mem_req && req_prev && words_sent < LINE_WORDS) begin
                mem_val  = 1'b1;
                mem_data = mem_word(mem_addr + 32'(4 * words_sent));
                words_sent++;
            end else begin
                mem_val = 1'b0;
                if (!mem_req) words_sent = 0;
            end
            req_prev = mem_req;
        end
    end

    always @(negedge clk) begin
        if (reset && hit) begin
            check("hit_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check("instr", instr, mon_e.data);
            end
        end
    end

    task automatic fetch(input logic [31:0] a, input string tag);
        bit          exp_hit, seen;
        int          lat, req_cyc;
        logic [31:0] req_addr;
        exp_t        e;
        exp_hit = model_access(a);
        @(posedge clk); #1;
        e.addr = a;
        e.data = mem_word(a);
        sb_q.push_back(e);
        ins_req   = 1'b1;
        instraddr = a;
        @(posedge clk); #1;
        ins_req  = 1'b0;
        seen     = 1'b0;
        lat      = -1;
        req_cyc  = 0;
        req_addr = '0;
        for (int c = 0; c < 4 * MISS_LAT && !seen; c++) begin
            @(negedge clk);
            if (mem_req) begin
                req_cyc++;
                req_addr = mem_addr;
            end
            if (hit) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        check({tag, "_latency"}, 32'(lat), exp_hit ? 32'd0 : 32'(MISS_LAT));
        check({tag, "_memreq_cycles"}, 32'(req_cyc), exp_hit ? 32'd0 : 32'(LINE_WORDS + 1));
        if (!exp_hit) check({tag, "_mem_addr"}, req_addr, {a[31:OFF_W], {OFF_W{1'b0}}});
    endtask

    task automatic burst(input logic [31:0] base, input int n);
        int   exp_hits, hits, stalls, reqs;
        exp_t e;
        exp_hits = 0;
        hits     = 0;
        stalls   = 0;
        reqs     = 0;
        for (int i = 0; i <= n; i++) begin
            @(posedge clk); #1;
            if (i < n) begin
                e.addr = base + 32'(4 * i);
                e.data = mem_word(e.addr);
                if (model_access(e.addr)) exp_hits++;
                sb_q.push_back(e);
                ins_req   = 1'b1;
                instraddr = e.addr;
            end else begin
                ins_req = 1'b0;
            end
            @(negedge clk);
            if (i > 0 && hit) hits++;
            if (stall)   stalls++;
            if (mem_req) reqs++;
        end
        check("burst_hits", 32'(hits), 32'(exp_hits));
        check("burst_stall_cycles", 32'(stalls), 32'd0);
        check("burst_memreq_cycles", 32'(reqs), 32'd0);
    endtask

    task automatic issue_no_expect(input logic [31:0] a);
        @(posedge clk); #1;
        ins_req   = 1'b1;
        instraddr = a;
        @(posedge clk); #1;
        ins_req = 1'b0;
        for (int c = 0; c < 4 * MISS_LAT && words_sent < 3; c++) @(negedge clk);
        check("refill_started", 32'(words_sent >= 3), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  stall_cnt, hit_cnt;
        bit  released;
        logic [31:0] a;
        model_clear();

        #12;
        check("rst_hit", 32'(hit), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_instr", instr, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Cold miss, then a hit on the last word of the same line.
        fetch(32'h0000_0040, "t1_cold");
        fetch(32'h0000_005C, "t1_follow");
        burst(32'h0000_0040, LINE_WORDS);
`ifdef ICACHE_STATS_EN
        check("stat_misses_t2", stat_misses, 32'd1);
        check("stat_hits_t2", stat_hits, 32'd9);
`endif

        // Flush while idle: one stall cycle, then the line is gone.
        @(posedge clk); #1;
        flush     = 1'b1;
        stall_cnt = 0;
        @(negedge clk);
        if (stall) stall_cnt++;
        @(posedge clk); #1;
        flush = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (stall) stall_cnt++;
        end
        check("flush_stall_cycles", 32'(stall_cnt), 32'd1);
        model_clear();
        fetch(32'h0000_0040, "t4_refetch");

        // Flush during a refill: the refill finishes, no hit, and the line is invalid afterwards.
        issue_no_expect(32'h0000_0080);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        released = 1'b0;
        hit_cnt  = 0;
        for (int c = 0; c < 4 * MISS_LAT && !released; c++) begin
            @(negedge clk);
            if (hit) hit_cnt++;
            if (!stall) released = 1'b1;
        end
        check("flush_mid_refill_release", 32'(released), 32'd1);
        check("flush_mid_refill_hits", 32'(hit_cnt), 32'd0);
        model_clear();
        fetch(32'h0000_0080, "t4b_refetch");

        // LRU: three tags in set 2 of a 2-way cache.
        fetch(32'h0000_0040, "lru_a");
        fetch(32'h0000_0144, "lru_b");
        fetch(32'h0000_0048, "lru_a2");
        fetch(32'h0000_014C, "lru_b2");
        fetch(32'h0000_0250, "lru_c");
        fetch(32'h0000_0154, "lru_b3");
        fetch(32'h0000_0058, "lru_a3");
        fetch(32'h0000_0240, "lru_c2");

        // Mixed traffic over two sets, three tags each, with byte offsets that must be ignored.
        for (int i = 0; i < 24; i++) begin
            a = (32'($urandom_range(0, 2)) << 8)
              | (($urandom_range(0, 1) != 0 ? 32'd5 : 32'd2) << OFF_W)
              | (32'($urandom_range(0, LINE_WORDS - 1)) << 2)
              | 32'($urandom_range(0, 3));
            fetch(a, "rnd");
        end

        // Asynchronous reset in the middle of a refill.
        issue_no_expect(32'h0000_03C0);
        @(negedge clk); #2;
        reset = 1'b0;
        #1;
        check("t5_mem_req", 32'(mem_req), 32'd0);
        check("t5_stall", 32'(stall), 32'd0);
        check("t5_hit", 32'(hit), 32'd0);
        check("t5_mem_addr", mem_addr, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        fetch(32'h0000_03C4, "t5_refetch");
`ifdef ICACHE_STATS_EN
        check("stat_misses_t5", stat_misses, 32'd1);
        check("stat_hits_t5", stat_hits, 32'd0);
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
